// File: rtl/ellipse_pkg.sv
// Shared register map, pipeline latency and reset defaults for the ellipse renderer.
package ellipse_pkg;
   localparam int LAT = 3;

   localparam logic [2:0] REG_CX     = 3'd0;
   localparam logic [2:0] REG_CY     = 3'd1;
   localparam logic [2:0] REG_W      = 3'd2;
   localparam logic [2:0] REG_H      = 3'd3;
   localparam logic [2:0] REG_COLOUR = 3'd4;
   localparam logic [2:0] REG_ENABLE = 3'd5;
   localparam logic [2:0] REG_RSVD   = 3'd6;
   localparam logic [2:0] REG_COMMIT = 3'd7;

   // Default colour is this bit replicated across the full colour width.
   localparam logic DEF_COLOUR_BIT = 1'b1;
   localparam logic DEF_ENABLE     = 1'b1;
endpackage

// File: rtl/ellipse_cfg_regs.sv
// Shadow/active configuration banks for one ellipse shape; a commit beat copies the
// shadow bank into the active bank together with the squared-radius constants.
module ellipse_cfg_regs
   import ellipse_pkg::*;
#(
   parameter int SHAPE_ID = 0,
   parameter int X_W      = 11,
   parameter int Y_W      = 12,
   parameter int DATA_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      program_in,
   input  logic [X_W-1:0]            x,
   input  logic [Y_W-1:0]            y,
   input  logic [DATA_W-1:0]         data_in,
   output logic [X_W-1:0]            cx,
   output logic [Y_W-1:0]            cy,
   output logic [2*X_W-1:0]          a2,
   output logic [2*Y_W-1:0]          b2,
   output logic [2*(X_W+Y_W)-1:0]    bound,
   output logic [DATA_W-1:0]         colour,
   output logic                      enable,
   output logic                      degen
);
   localparam int A2_W    = 2 * X_W;
   localparam int B2_W    = 2 * Y_W;
   localparam int BOUND_W = 2 * (X_W + Y_W);

   logic [X_W-1:0]     sh_cx;
   logic [Y_W-1:0]     sh_cy;
   logic [X_W-1:0]     sh_w;
   logic [Y_W-1:0]     sh_h;
   logic [DATA_W-1:0]  sh_colour;
   logic               sh_enable;

   logic               wr;
   logic [A2_W-1:0]    a2_n;
   logic [B2_W-1:0]    b2_n;
   logic [BOUND_W-1:0] bound_n;

   // Register IDs above 7 must not alias onto the low eight.
   assign wr      = program_in && (x == X_W'(SHAPE_ID)) && (y[Y_W-1:3] == '0);
   assign a2_n    = A2_W'(sh_w) * A2_W'(sh_w);
   assign b2_n    = B2_W'(sh_h) * B2_W'(sh_h);
   assign bound_n = BOUND_W'(a2_n) * BOUND_W'(b2_n);

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_cx     <= '0;
         sh_cy     <= '0;
         sh_w      <= '0;
         sh_h      <= '0;
         sh_colour <= {DATA_W{DEF_COLOUR_BIT}};
         sh_enable <= DEF_ENABLE;
         cx        <= '0;
         cy        <= '0;
         a2        <= '0;
         b2        <= '0;
         bound     <= '0;
         colour    <= {DATA_W{DEF_COLOUR_BIT}};
         enable    <= DEF_ENABLE;
         degen     <= 1'b1;
      end else if (wr) begin
         case (y[2:0])
            REG_CX:     sh_cx     <= data_in[X_W-1:0];
            REG_CY:     sh_cy     <= data_in[Y_W-1:0];
            REG_W:      sh_w      <= data_in[X_W-1:0];
            REG_H:      sh_h      <= data_in[Y_W-1:0];
            REG_COLOUR: sh_colour <= data_in;
            REG_ENABLE: sh_enable <= data_in[0];
            REG_RSVD:   ;
            REG_COMMIT: begin
               cx     <= sh_cx;
               cy     <= sh_cy;
               a2     <= a2_n;
               b2     <= b2_n;
               bound  <= bound_n;
               colour <= sh_colour;
               enable <= sh_enable;
               degen  <= (sh_w == '0) || (sh_h == '0);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/ellipse_renderer_pipe.sv
// Three-stage ellipse shader in the render chain. Optional ELLIPSE_RENDERER_ALPHA_BLEND_EN
// blends inside pixels using colour[31:24] as alpha instead of replacing them.
module ellipse_renderer_pipe
   import ellipse_pkg::*;
#(
   parameter int SHAPE_ID = 0,
   parameter int X_W      = 11,
   parameter int Y_W      = 12,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              program_in,
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   input  logic [DATA_W-1:0] data_in,
   output logic              program_out,
   output logic [X_W-1:0]    x_out,
   output logic [Y_W-1:0]    y_out,
   output logic [DATA_W-1:0] data_out
);
   localparam int A2_W    = 2 * X_W;
   localparam int B2_W    = 2 * Y_W;
   localparam int BOUND_W = 2 * (X_W + Y_W);
   localparam int CALC_W  = BOUND_W + 1;

   logic [X_W-1:0]     act_cx;
   logic [Y_W-1:0]     act_cy;
   logic [A2_W-1:0]    act_a2;
   logic [B2_W-1:0]    act_b2;
   logic [BOUND_W-1:0] act_bound;
   logic [DATA_W-1:0]  act_colour;
   logic               act_enable;
   logic               act_degen;

   ellipse_cfg_regs #(
      .SHAPE_ID (SHAPE_ID),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .DATA_W   (DATA_W)
   ) u_cfg (
      .clk        (clk),
      .rst        (rst),
      .program_in (program_in),
      .x          (x),
      .y          (y),
      .data_in    (data_in),
      .cx         (act_cx),
      .cy         (act_cy),
      .a2         (act_a2),
      .b2         (act_b2),
      .bound      (act_bound),
      .colour     (act_colour),
      .enable     (act_enable),
      .degen      (act_degen)
   );

   logic [LAT-1:0]            program_pipe;
   logic [X_W-1:0]            x_p1, x_p2, x_p3;
   logic [Y_W-1:0]            y_p1, y_p2, y_p3;
   logic [DATA_W-1:0]         data_p1, data_p2, data_p3;
   logic [X_W-1:0]            dx_p1;
   logic [Y_W-1:0]            dy_p1;
   logic [A2_W-1:0]           dx2_p2, a2_p1, a2_p2;
   logic [B2_W-1:0]           dy2_p2, b2_p1, b2_p2;
   logic [BOUND_W-1:0]        bound_p1, bound_p2;
   logic [DATA_W-1:0]         colour_p1, colour_p2;
   logic                      enable_p1, enable_p2, degen_p1, degen_p2;

   logic signed [X_W:0]       diff_x;
   logic signed [Y_W:0]       diff_y;
   logic [X_W-1:0]            dx;
   logic [Y_W-1:0]            dy;
   logic [CALC_W-1:0]         calc;
   logic                      inshape;
   logic [DATA_W-1:0]         inside_val;

   // Widen by one bit so the difference never wraps before taking the magnitude.
   assign diff_x = $signed({1'b0, x}) - $signed({1'b0, act_cx});
   assign diff_y = $signed({1'b0, y}) - $signed({1'b0, act_cy});
   assign dx     = diff_x[X_W] ? X_W'(-diff_x) : X_W'(diff_x);
   assign dy     = diff_y[Y_W] ? Y_W'(-diff_y) : Y_W'(diff_y);

   assign calc    = CALC_W'(b2_p2) * CALC_W'(dx2_p2) + CALC_W'(a2_p2) * CALC_W'(dy2_p2);
   assign inshape = enable_p2 && !degen_p2 && (calc <= CALC_W'(bound_p2));

`ifdef ELLIPSE_RENDERER_ALPHA_BLEND_EN
   function automatic logic [31:0] blend(input logic [31:0] c, input logic [31:0] d);
      logic [8:0]  ap;
      logic [15:0] acc;
      ap = {1'b0, c[31:24]} + {8'd0, c[31]};
      blend[31:24] = d[31:24];
      for (int k = 0; k < 3; k++) begin
         acc = 16'(c[8*k +: 8]) * 16'(ap) + 16'(d[8*k +: 8]) * 16'(9'd256 - ap);
         blend[8*k +: 8] = 8'(acc >> 8);
      end
   endfunction

   assign inside_val = DATA_W'(blend(32'(colour_p2), 32'(data_p2)));
`else
   assign inside_val = colour_p2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         program_pipe <= '0;
         {x_p1, x_p2, x_p3}          <= '0;
         {y_p1, y_p2, y_p3}          <= '0;
         {data_p1, data_p2, data_p3} <= '0;
         {dx_p1, dy_p1, dx2_p2, dy2_p2} <= '0;
         {a2_p1, a2_p2, b2_p1, b2_p2}   <= '0;
         {bound_p1, bound_p2}           <= '0;
         {colour_p1, colour_p2}         <= '0;
         {enable_p1, enable_p2, degen_p1, degen_p2} <= '0;
      end else begin
         program_pipe <= {program_pipe[LAT-2:0], program_in};
         // stage 1: distances plus a snapshot of the active set for this beat
         x_p1      <= x;
         y_p1      <= y;
         data_p1   <= data_in;
         dx_p1     <= dx;
         dy_p1     <= dy;
         a2_p1     <= act_a2;
         b2_p1     <= act_b2;
         bound_p1  <= act_bound;
         colour_p1 <= act_colour;
         enable_p1 <= act_enable;
         degen_p1  <= act_degen;
         // stage 2: squared distances
         x_p2      <= x_p1;
         y_p2      <= y_p1;
         data_p2   <= data_p1;
         dx2_p2    <= A2_W'(dx_p1) * A2_W'(dx_p1);
         dy2_p2    <= B2_W'(dy_p1) * B2_W'(dy_p1);
         a2_p2     <= a2_p1;
         b2_p2     <= b2_p1;
         bound_p2  <= bound_p1;
         colour_p2 <= colour_p1;
         enable_p2 <= enable_p1;
         degen_p2  <= degen_p1;
         // stage 3: inside test and colour substitution
         x_p3      <= x_p2;
         y_p3      <= y_p2;
         data_p3   <= (!program_pipe[1] && inshape) ? inside_val : data_p2;
      end
   end

   assign program_out = program_pipe[LAT-1];
   assign x_out       = x_p3;
   assign y_out       = y_p3;
   assign data_out    = data_p3;
endmodule

// File: tb/tb_ellipse_renderer_pipe.sv
// Bench for ellipse_renderer_pipe: directed beats with pinned values plus random traffic,
// all checked against an ellipse-inequality model through a due-cycle queue.
module tb_ellipse_renderer_pipe;
   localparam int SHAPE_ID = 5;
   localparam int X_W      = 11;
   localparam int Y_W      = 12;
   localparam int DATA_W   = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              program_in;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [DATA_W-1:0] data_in;
   logic              program_out;
   logic [X_W-1:0]    x_out;
   logic [Y_W-1:0]    y_out;
   logic [DATA_W-1:0] data_out;

   ellipse_renderer_pipe #(
      .SHAPE_ID (SHAPE_ID),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .DATA_W   (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .program_in  (program_in),
      .x           (x),
      .y           (y),
      .data_in     (data_in),
      .program_out (program_out),
      .x_out       (x_out),
      .y_out       (y_out),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                due;
      logic              prog;
      logic [X_W-1:0]    xv;
      logic [Y_W-1:0]    yv;
      logic [DATA_W-1:0] d;
   } exp_t;

   typedef struct {
      int          cx, cy, w, h;
      logic [31:0] col;
      bit          en;
   } cfg_t;

   exp_t expq[$];
   exp_t ce;
   cfg_t sh, act;
   int   checks = 0;
   int   errors = 0;

   function automatic cfg_t cfg_default();
      cfg_t c;
      c.cx = 0; c.cy = 0; c.w = 0; c.h = 0;
      c.col = 32'hFFFF_FFFF;
      c.en = 1'b1;
      return c;
   endfunction

   // Point is inside when (dx/w)^2 + (dy/h)^2 <= 1, cleared of denominators.
   function automatic logic [31:0] model(input logic p, input int xi, input int yi,
                                         input logic [31:0] d);
      longint unsigned dx, dy, w, h;
      if (p || !act.en || act.w == 0 || act.h == 0) return d;
      dx = (xi > act.cx) ? longint'(xi - act.cx) : longint'(act.cx - xi);
      dy = (yi > act.cy) ? longint'(yi - act.cy) : longint'(act.cy - yi);
      w  = longint'(act.w);
      h  = longint'(act.h);
      if (h*h*dx*dx + w*w*dy*dy <= w*w*h*h) return act.col;
      return d;
   endfunction

   task automatic apply_cfg(input logic p, input int xi, input int yi, input logic [31:0] d);
      if (!p || xi != SHAPE_ID) return;
      case (yi)
         0: sh.cx  = int'(d[X_W-1:0]);
         1: sh.cy  = int'(d[Y_W-1:0]);
         2: sh.w   = int'(d[X_W-1:0]);
         3: sh.h   = int'(d[Y_W-1:0]);
         4: sh.col = d;
         5: sh.en  = d[0];
         7: act    = sh;
         default: ;
      endcase
   endtask

   task automatic beat(input logic p, input int xi, input int yi, input logic [31:0] d,
                       input bit pin = 1'b0, input logic [31:0] lit = '0);
      exp_t        e;
      logic [31:0] m;
      @(posedge clk); #1;
      rst        = 1'b0;
      program_in = p;
      x          = X_W'(xi);
      y          = Y_W'(yi);
      data_in    = d;
      m = model(p, xi, yi, d);
      if (pin) begin
         checks++;
         if (m !== lit) begin
            errors++;
            $display("FAIL model_pin (%0d,%0d): model %h, required %h", xi, yi, m, lit);
         end
      end
      e.due  = cyc + 3;
      e.prog = p;
      e.xv   = X_W'(xi);
      e.yv   = Y_W'(yi);
      e.d    = m;
      expq.push_back(e);
      apply_cfg(p, xi, yi, d);
   endtask

   task automatic do_reset(input int n);
      exp_t z;
      z.prog = 1'b0; z.xv = '0; z.yv = '0; z.d = '0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rst        = 1'b1;
         program_in = 1'($urandom);
         x          = X_W'($urandom);
         y          = Y_W'($urandom);
         data_in    = $urandom;
         while (expq.size() > 0 && expq[$].due >= cyc + 1) void'(expq.pop_back());
         z.due = cyc + 1;
         expq.push_back(z);
      end
      z.due = cyc + 2; expq.push_back(z);
      z.due = cyc + 3; expq.push_back(z);
      sh  = cfg_default();
      act = cfg_default();
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (expq.size() > 0 && expq[0].due < cyc) begin
            ce = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL beat_missed: beat due at cycle %0d, now at cycle %0d", ce.due, cyc);
         end
         if (expq.size() > 0 && expq[0].due == cyc) begin
            ce = expq.pop_front();
            checks++;
            if (program_out !== ce.prog || x_out !== ce.xv || y_out !== ce.yv || data_out !== ce.d) begin
               errors++;
               $display("FAIL beat_out cyc %0d: got p=%0b x=%0d y=%0d d=%h, required p=%0b x=%0d y=%0d d=%h",
                        cyc, program_out, x_out, y_out, data_out, ce.prog, ce.xv, ce.yv, ce.d);
            end
         end
      end
   end

   initial begin
      int          r, id, xi, yi;
      logic [31:0] d;
      rst = 1'b1; program_in = 1'b0; x = '0; y = '0; data_in = '0;
      sh  = cfg_default();
      act = cfg_default();

      do_reset(2);
      beat(0, 5, 5, 32'h1111_1111, 1, 32'h1111_1111);

      beat(1, SHAPE_ID, 0, 100);
      beat(1, SHAPE_ID, 1, 100);
      beat(1, SHAPE_ID, 2, 10);
      beat(1, SHAPE_ID, 3, 5);
      beat(1, SHAPE_ID, 4, 32'hFF00_FF00);
      beat(1, SHAPE_ID, 7, 32'h0, 1, 32'h0);
      beat(0, 110, 100, 0, 1, 32'hFF00_FF00);
      beat(0, 111, 100, 0, 1, 32'h0);
      beat(0, 100, 105, 0, 1, 32'hFF00_FF00);
      beat(0, 100, 106, 0, 1, 32'h0);

      beat(1, SHAPE_ID, 2, 20);
      beat(0, 115, 100, 32'hAAAA_5555, 1, 32'hAAAA_5555);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 115, 100, 32'hAAAA_5555, 1, 32'hFF00_FF00);

      beat(1, SHAPE_ID, 2, 1);
      beat(1, SHAPE_ID, 7, 0);
      beat(1, SHAPE_ID, 2, 2);
      beat(0, 102, 100, 32'h1234_5678, 1, 32'h1234_5678);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 102, 100, 32'h1234_5678, 1, 32'hFF00_FF00);

      beat(1, SHAPE_ID, 0, 0);
      beat(1, SHAPE_ID, 1, 0);
      beat(1, SHAPE_ID, 2, 2047);
      beat(1, SHAPE_ID, 3, 4095);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 2047, 0, 0, 1, 32'hFF00_FF00);
      beat(0, 2047, 1, 0, 1, 32'h0);
      beat(0, 0, 4095, 0, 1, 32'hFF00_FF00);
      beat(0, 2047, 4095, 0, 1, 32'h0);

      beat(1, SHAPE_ID, 0, 32'h1234_0064);
      beat(1, SHAPE_ID, 1, 100);
      beat(1, SHAPE_ID, 2, 10);
      beat(1, SHAPE_ID, 3, 5);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 110, 100, 0, 1, 32'hFF00_FF00);

      beat(1, SHAPE_ID, 5, 0);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 100, 100, 32'h55, 1, 32'h55);
      beat(1, 3, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
      beat(1, SHAPE_ID, 5, 1);
      beat(1, 4, 7, 0);
      beat(1, SHAPE_ID, 15, 0);
      beat(1, SHAPE_ID, 6, 0);
      beat(0, 100, 100, 32'h55, 1, 32'h55);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 100, 100, 32'h55, 1, 32'hFF00_FF00);

      beat(1, SHAPE_ID, 0, 500);
      beat(1, SHAPE_ID, 1, 500);
      beat(1, SHAPE_ID, 2, 40);
      beat(1, SHAPE_ID, 3, 30);
      beat(1, SHAPE_ID, 4, $urandom);
      beat(1, SHAPE_ID, 7, 0);
      for (int i = 0; i < 800; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 15) begin
            id = int'($urandom_range(0, 11));
            if (id > 9) id = 7;
            case (id)
               0, 1:    d = 32'($urandom_range(400, 600));
               2, 3:    d = 32'($urandom_range(0, 60));
               5: begin
                  d = $urandom;
                  d[0] = ($urandom_range(0, 4) != 0);
               end
               default: d = $urandom;
            endcase
            xi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : SHAPE_ID;
            beat(1, xi, id, d);
         end else begin
            xi = act.cx + int'($urandom_range(0, 140)) - 70;
            yi = act.cy + int'($urandom_range(0, 140)) - 70;
            if (xi < 0) xi = 0;
            if (yi < 0) yi = 0;
            beat(0, xi, yi, $urandom);
         end
      end

      beat(0, 500, 500, 32'h0101_0101);
      beat(1, SHAPE_ID, 4, 32'h0F0F_0F0F);
      beat(0, 501, 499, 32'h0202_0202);
      do_reset(1);
      beat(0, 0, 0, 32'h1234_5678, 1, 32'h1234_5678);
      beat(1, SHAPE_ID, 7, 0);
      beat(0, 0, 0, 32'h1234_5678, 1, 32'h1234_5678);

      @(posedge clk); #1;
      program_in = 1'b0;
      for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d beats never emerged, required 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ellipse_renderer_pipe.md
Name: ellipse_renderer_pipe

Overview:
Parametrised, pipelined successor to the single-cycle ellipse shader in the per-shape renderer chain. It sits in the daisy-chained render pipeline and is programmed over the same program/x/y/data beat bus. It substitutes its colour into the pixel stream when the pixel lies inside an axis-aligned ellipse. New capabilities:
- double-buffered (shadow/active) configuration with an atomic commit
- enable bit and degenerate-radius suppression
- a fixed 3-cycle pipeline for timing closure

Parameters:
SHAPE_ID, 0, shape address matched against x on programming beats; must be < 2**X_W
X_W, 11, x coordinate / width-radius width
Y_W, 12, y coordinate / height-radius width
DATA_W, 32, pixel/colour width; must be 32 when ALPHA_BLEND_EN is defined

Ports:
clk  in  1  clock
rst  in  1  reset
program_in  in  1  beat is a programming beat, not a pixel
x  in  X_W  pixel x, or target shape ID when programming
y  in  Y_W  pixel y, or register ID when programming
data_in  in  DATA_W  upstream pixel colour, or register write data
program_out  out  1  program_in delayed by LAT
x_out  out  X_W  x delayed by LAT
y_out  out  Y_W  y delayed by LAT
data_out  out  DATA_W  rendered pixel, or data_in delayed by LAT

Interface: one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- LAT = 3. Every input beat, pixel or programming, emerges on all outputs exactly 3 cycles later; no stalls, no bubbles; throughput 1 beat/cycle.
- Programming write: program_in=1 and x==SHAPE_ID writes the shadow register selected by y, taking effect next cycle. Register IDs:
  - 0 cx (X_W bits)
  - 1 cy (Y_W bits)
  - 2 w (X_W bits)
  - 3 h (Y_W bits)
  - 4 colour (DATA_W bits)
  - 5 enable (data_in[0])
  - 6 reserved, ignored
  - 7 commit
  - ID>7 ignored
  - Wide fields take the low bits of data_in.
- Commit (ID 7, data ignored): copies all shadow regs into the active set at the clock edge sampling the beat. Derived constants are registered at the same time: a2=w*w (2*X_W bits), b2=h*h (2*Y_W bits), bound=a2*b2 (2*(X_W+Y_W) bits). Shadow writes without a commit never affect rendering.
- Per-beat active-set capture: stage 1 captures, alongside each beat, the active-set values it needs (cx, cy, a2, b2, bound, colour, enable, degenerate flag). A pixel entering on or after the cycle following the commit beat is rendered wholly with the new set; earlier pixels are rendered wholly with the old set. There is never a mixed-generation result.
- Stage 1: dx=|x-cx|, dy=|y-cy|, unsigned, no wrap. degen = (w==0 || h==0).
- Stage 2: dx2=dx*dx, dy2=dy*dy.
- Stage 3:
  - calc = b2*dx2 + a2*dy2, computed at 2*(X_W+Y_W)+1 bits with no truncation.
  - inshape = enable && !degen && calc<=bound. Boundary pixels (calc==bound) are inside.
  - data_out = (!program && inshape) ? colour : data.
- Programming beats always pass through unmodified, including beats addressed to this shape and commit beats.
- Reset:
  - All outputs 0 the cycle after rst is sampled high.
  - Pipeline contents discarded.
  - Shadow and active sets return to cx=cy=w=h=0, colour=all ones, enable=1; derived constants 0.
  - Degenerate at reset, so nothing renders until a commit with w,h nonzero.
- Reset mid-stream: in-flight beats are lost, with no partial outputs. The first post-reset input appears on the outputs 3 cycles after rst deasserts.

Optional Feature:
ELLIPSE_RENDERER_ALPHA_BLEND_EN
- Defined:
  - Inside pixels are blended, with a = colour[31:24] and a' = a + a[7] (range 0..256).
  - Each 8-bit channel k in {0,1,2}: out_k = (c_k*a' + d_k*(256-a')) >> 8.
  - out[31:24] = d[31:24].
  - Computed in stage 3; latency unchanged.
- Undefined: straight colour replacement, as above.

Decomposition:
- Package ellipse_pkg: register ID constants (REG_CX..REG_COMMIT), LAT=3, default colour, default enable.
- Sub-module ellipse_cfg_regs:
  - holds shadow/active banks and derived-constant registers
  - handles address decode and commit
  - parametrised by SHAPE_ID, X_W, Y_W, DATA_W
- Top level holds the 3-stage datapath.

Test Plan:
1. Reset, then stream pixel (5,5) data 0x11111111 → 3 cycles later data_out=0x11111111 (degenerate default), x_out=5, y_out=5.
2. Program cx=100, cy=100, w=10, h=5, colour=0xFF00FF00, commit. Then pixels (110,100), (111,100), (100,105), (100,106), data 0 → outputs 0xFF00FF00, 0, 0xFF00FF00, 0.
3. Shadow-write w=20 without commit, pixel (115,100) → unchanged data_in. Commit followed immediately by the same pixel → colour.
4. Commit w=2 back-to-back with pixels A (on the commit cycle's neighbours) and B (cycle after commit), both at (102,100) with initial w=1 → A passes data_in, B gets colour. No mixed result.
5. Write enable=0 + commit → no pixel recoloured. A programming beat with x≠SHAPE_ID passes through with data unchanged and program_out=1 after 3 cycles.
6. Assert rst for 1 cycle with 3 beats in flight → outputs 0 next cycle. Active set back to defaults; a subsequent pixel at (0,0) is not recoloured.
